// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared definitions for the accumulator-machine sequencer.
//
// Holds the opcode values, the control-bus bit positions, the sequencer
// state enum and two small opcode helpers used by the next-state logic.
//
// Build option: CTRL_COND_JMP_EN
//   defined   -> JZ (5) and JC (6) are legal conditional jumps
//   undefined -> JZ and JC are treated as illegal opcodes (run as NOP)

package ctrl_pkg;

  // Opcodes (low nibble of the IR value)
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_JC  = 4'h6;
  localparam logic [3:0] OP_NOP = 4'h7;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control bus bit positions (active-high)
  localparam int CB_PC_INC  = 0;
  localparam int CB_PC_OUT  = 1;
  localparam int CB_PC_LD   = 2;
  localparam int CB_MAR_LD  = 3;
  localparam int CB_RAM_OUT = 4;
  localparam int CB_RAM_LD  = 5;
  localparam int CB_IR_LD   = 6;
  localparam int CB_IR_OUT  = 7;
  localparam int CB_A_LD    = 8;
  localparam int CB_A_OUT   = 9;
  localparam int CB_B_LD    = 10;
  localparam int CB_ALU_OUT = 11;
  localparam int CB_ALU_SUB = 12;
  localparam int CB_FLAG_LD = 13;
  localparam int CB_OUT_LD  = 14;
  localparam int CB_HLT     = 15;

  // Width of the architected part of the control bus
  localparam int CW_BASE_W = 16;

`ifdef CTRL_COND_JMP_EN
  localparam bit COND_JMP_EN = 1'b1;
`else
  localparam bit COND_JMP_EN = 1'b0;
`endif

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  // True when the low nibble names an implemented instruction.
  // Opcodes 8..D are always illegal; 5 and 6 only exist with the
  // conditional-jump option.
  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    case (op)
      OP_JZ, OP_JC: ok = COND_JMP_EN;
      4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD: ok = 1'b0;
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Number of execute T-states (T4 onward) for a legal opcode.
  // Zero means the instruction ends after the fetch (T3).
  function automatic logic [1:0] exec_len(input logic [3:0] op);
    logic [1:0] n;
    case (op)
      OP_LDA, OP_STA: n = 2'd2;
      OP_ADD, OP_SUB: n = 2'd3;
      OP_JMP, OP_JZ, OP_JC, OP_OUT, OP_HLT: n = 2'd1;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode -- combinational control-word decoder.
//
// Maps the state the sequencer is about to enter, the (already legalised)
// opcode and the sampled flags onto the 16-bit control word that will be
// registered alongside that state.
//
// Ports:
//   nxt_state  in   state being entered on this clock edge
//   op         in   4-bit opcode; illegal opcodes arrive here as NOP
//   zf, cf     in   flags sampled at the T3->T4 edge
//   cw         out  16-bit control word for nxt_state
//
// Build option: CTRL_COND_JMP_EN (only affects which opcodes reach this
// block; the decode table itself is unconditional).

module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_t      nxt_state,
  input  logic [3:0]  op,
  input  logic        zf,
  input  logic        cf,
  output logic [15:0] cw
);

  always_comb begin
    cw = '0;
    case (nxt_state)
      S_T1: begin
        cw[CB_PC_OUT] = 1'b1;
        cw[CB_MAR_LD] = 1'b1;
      end
      S_T2: begin
        cw[CB_PC_INC] = 1'b1;
      end
      S_T3: begin
        cw[CB_RAM_OUT] = 1'b1;
        cw[CB_IR_LD]   = 1'b1;
      end
      S_T4: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw[CB_IR_OUT] = 1'b1;
            cw[CB_MAR_LD] = 1'b1;
          end
          OP_JMP: begin
            cw[CB_IR_OUT] = 1'b1;
            cw[CB_PC_LD]  = 1'b1;
          end
          // A jump not taken drives an all-zero word rather than just
          // suppressing pc_ld, so the IR is not put on the bus needlessly.
          OP_JZ: begin
            if (zf) begin
              cw[CB_IR_OUT] = 1'b1;
              cw[CB_PC_LD]  = 1'b1;
            end
          end
          OP_JC: begin
            if (cf) begin
              cw[CB_IR_OUT] = 1'b1;
              cw[CB_PC_LD]  = 1'b1;
            end
          end
          OP_OUT: begin
            cw[CB_A_OUT]  = 1'b1;
            cw[CB_OUT_LD] = 1'b1;
          end
          OP_HLT: begin
            cw[CB_HLT] = 1'b1;
          end
          default: cw = '0;
        endcase
      end
      S_T5: begin
        case (op)
          OP_LDA: begin
            cw[CB_RAM_OUT] = 1'b1;
            cw[CB_A_LD]    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CB_RAM_OUT] = 1'b1;
            cw[CB_B_LD]    = 1'b1;
          end
          OP_STA: begin
            cw[CB_A_OUT]  = 1'b1;
            cw[CB_RAM_LD] = 1'b1;
          end
          default: cw = '0;
        endcase
      end
      S_T6: begin
        if (op == OP_ADD || op == OP_SUB) begin
          cw[CB_ALU_OUT] = 1'b1;
          cw[CB_A_LD]    = 1'b1;
          cw[CB_FLAG_LD] = 1'b1;
          cw[CB_ALU_SUB] = (op == OP_SUB);
        end
      end
      S_HALT: begin
        cw[CB_HLT] = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq -- microprogram sequencer for the 8-bit accumulator machine.
//
// Steps IDLE -> T1..T3 (fetch) -> T4..T6 (execute, variable length) and
// back to T1, or to IDLE when run is low at an instruction boundary.
// HLT parks the sequencer in HALT until clr. All state and output
// registers update on the falling clock edge so the datapath, which
// latches on the rising edge, sees a stable control word.
//
// Parameters:
//   OPC_W  opcode width (>=4); any bit above bit 3 set makes it illegal
//   CW_W   control bus width (>=16); bits above 15 are always 0
//   TS_W   one-hot t_state width (>=6)
//
// Ports:
//   clk          in   system clock (falling-edge active)
//   clr          in   asynchronous active-low reset
//   run          in   permits the next instruction; sampled only at
//                     instruction boundaries and in IDLE
//   instruction  in   opcode from the IR, sampled at the T3->T4 edge
//   zf, cf       in   zero/carry flags, sampled at the T3->T4 edge
//   out          out  registered one-hot-per-function control bus
//   t_state      out  one-hot T-state (bit0 = T1); zero in IDLE/HALT
//   halted       out  high while in HALT
//   ill_op       out  one-cycle pulse in the cycle after T3 of an
//                     illegal opcode
//
// Build option: CTRL_COND_JMP_EN enables JZ/JC; without it opcodes 5 and
// 6 are illegal and zf/cf are ignored.

module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 4,
  parameter int CW_W  = 16,
  parameter int TS_W  = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [OPC_W-1:0] instruction,
  input  logic             zf,
  input  logic             cf,
  output logic [CW_W-1:0]  out,
  output logic [TS_W-1:0]  t_state,
  output logic             halted,
  output logic             ill_op
);

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic              zf_q, zf_d;
  logic              cf_q, cf_d;
  logic [CW_W-1:0]   out_q, out_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              halted_q, halted_d;
  logic              ill_q, ill_d;

  logic              op_hi_set;
  logic              fetch_legal;
  logic [3:0]        fetch_op;
  state_t            boundary_state;
  logic [15:0]       cw_d;

  // Legalise the opcode on the IR. Illegal values are replaced by NOP so
  // the rest of the sequencer never has to know about them.
  always_comb begin
    op_hi_set   = |(instruction >> 4);
    fetch_legal = !op_hi_set && op_legal(instruction[3:0]);
    fetch_op    = fetch_legal ? instruction[3:0] : OP_NOP;
  end

  // Where to go after the last T-state of an instruction.
  always_comb begin
    boundary_state = run ? S_T1 : S_IDLE;
  end

  // Next-state logic. The opcode and flags are captured on the edge that
  // leaves T3; during T3 itself the live IR value decides whether the
  // instruction has any execute states at all.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    zf_d    = zf_q;
    cf_d    = cf_q;
    ill_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_T1;
      end
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: begin
        op_d  = fetch_op;
`ifdef CTRL_COND_JMP_EN
        zf_d  = zf;
        cf_d  = cf;
`endif
        ill_d = !fetch_legal;
        if (exec_len(fetch_op) == 2'd0) state_d = boundary_state;
        else                            state_d = S_T4;
      end
      S_T4: begin
        if (op_q == OP_HLT)                 state_d = S_HALT;
        else if (exec_len(op_q) > 2'd1)     state_d = S_T5;
        else                                state_d = boundary_state;
      end
      S_T5: begin
        if (exec_len(op_q) > 2'd2) state_d = S_T6;
        else                       state_d = boundary_state;
      end
      S_T6:   state_d = boundary_state;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // The control word is decoded from the state being entered so that it
  // is registered on the same edge as the state itself.
  ctrl_decode u_decode (
    .nxt_state (state_d),
    .op        (op_d),
    .zf        (zf_d),
    .cf        (cf_d),
    .cw        (cw_d)
  );

  always_comb begin
    out_d    = CW_W'(cw_d);
    halted_d = (state_d == S_HALT);
    ts_d     = '0;
    case (state_d)
      S_T1:    ts_d[0] = 1'b1;
      S_T2:    ts_d[1] = 1'b1;
      S_T3:    ts_d[2] = 1'b1;
      S_T4:    ts_d[3] = 1'b1;
      S_T5:    ts_d[4] = 1'b1;
      S_T6:    ts_d[5] = 1'b1;
      default: ts_d = '0;
    endcase
  end

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NOP;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
      out_q    <= '0;
      ts_q     <= '0;
      halted_q <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
      out_q    <= out_d;
      ts_q     <= ts_d;
      halted_q <= halted_d;
      ill_q    <= ill_d;
    end
  end

  assign out     = out_q;
  assign t_state = ts_q;
  assign halted  = halted_q;
  assign ill_op  = ill_q;

`ifndef CTRL_COND_JMP_EN
  // Flags have no effect without conditional jumps.
  logic unused_flags;
  assign unused_flags = zf ^ cf;
`endif

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Parametrised microprogram sequencer for the 8-bit accumulator machine. It fetches an opcode through the IR, steps through a variable-length T-state sequence, and drives the one-hot control bus that the PC, MAR, RAM, IR, A, B, ALU and output register latch on the rising clock edge. It extends the basic LDA/ADD/SUB/OUT set with STA, JMP, conditional jumps, NOP and HLT. Instructions return to fetch after their last useful T-state, and a `run` input gates the start of each instruction.

## Interface
- `OPC_W`, 4: opcode width. Must be ≥4. Opcode values with any bit above bit 3 set are illegal.
- `CW_W`, 16: control bus width. Must be ≥16. Bits above 15 are tied to 0.
- `TS_W`, 6: width of the one-hot `t_state` output. Must be ≥6.
- `clk`, in, 1: system clock. State and control registers update on the falling edge.
- `clr`, in, 1: reset. Asynchronous, active-low.
- `run`, in, 1: permits the next instruction fetch.
- `instruction`, in, `OPC_W`: opcode from the IR.
- `zf`, in, 1: zero flag from the flag register.
- `cf`, in, 1: carry flag from the flag register.
- `out`, out, `CW_W`: registered control bus.
- `t_state`, out, `TS_W`: one-hot current T-state. All zero in IDLE and HALT.
- `halted`, out, 1: high in HALT.
- `ill_op`, out, 1: one-cycle pulse on an illegal opcode.

## Operation
- Control bits, active-high, index 0–15:
  - pc_inc, pc_out, pc_ld
  - mar_ld, ram_out, ram_ld
  - ir_ld, ir_out
  - a_ld, a_out, b_ld
  - alu_out, alu_sub, flag_ld
  - out_ld, hlt
- States: IDLE, T1–T6, HALT.
- Fetch sequence:
  - T1: pc_out, mar_ld.
  - T2: pc_inc.
  - T3: ram_out, ir_ld.
- Execute sequences (T4 onward):
  - LDA (0): T4 ir_out, mar_ld. T5 ram_out, a_ld.
  - ADD (1): T4 ir_out, mar_ld. T5 ram_out, b_ld. T6 alu_out, a_ld, flag_ld.
  - SUB (2): as ADD, with alu_sub added in T6.
  - STA (3): T4 ir_out, mar_ld. T5 a_out, ram_ld.
  - JMP (4): T4 ir_out, pc_ld.
  - JZ (5): T4 ir_out, pc_ld if `zf`, otherwise an all-zero word.
  - JC (6): T4 ir_out, pc_ld if `cf`, otherwise an all-zero word.
  - NOP (7) and all other unlisted opcodes: no execute states.
  - OUT (E): T4 a_out, out_ld.
  - HLT (F): T4 hlt, then HALT.
- After the last state of an instruction:
  - Go to T1 if `run`=1, otherwise to IDLE.
  - In IDLE, go to T1 on the first falling edge with `run`=1.
- Illegal opcodes:
  - Opcodes 8–D, and any opcode with a bit above bit 3 set, are illegal.
  - `ill_op` is high for the cycle following T3. The opcode then executes as a NOP.
- In HALT: `out` has only hlt set, and `halted`=1. Only `clr` exits HALT.
- `instruction`, `zf` and `cf` are sampled at the T3→T4 falling edge.

## Timing
- Reset (`clr`=0), asynchronously:
  - state = IDLE, `out`=0, `t_state`=0, `halted`=0, `ill_op`=0.
- Reset release: the first T1 starts on the first falling edge with `clr`=1 and `run`=1.
- `out` and `t_state` are registered on the same falling edge as the state. The datapath latches half a cycle later.
- Instruction lengths in cycles:
  - ADD, SUB: 6.
  - LDA, STA: 5.
  - JMP, JZ, JC, OUT: 4.
  - NOP and illegal opcodes: 3.
  - HLT: 4, then HALT.
- `run` is only sampled at instruction boundaries. Dropping `run` mid-instruction never truncates the instruction.
- `clr` asserted mid-instruction immediately forces IDLE and `out`=0, regardless of state.

## Configuration
- `CTRL_COND_JMP_EN` defined: JZ and JC behave as specified above.
- `CTRL_COND_JMP_EN` undefined:
  - Opcodes 5 and 6 are illegal: `ill_op` pulses and they execute as NOP.
  - `zf` and `cf` are unused.

## Structure
- Package `ctrl_pkg` holds:
  - Opcode localparams.
  - Control bit index constants.
  - State enum typedef.
- Sub-module `ctrl_decode` is combinational. It maps next state, opcode and flags to the control word.
- `ctrl_seq` holds the state register, the `run` gating, and the `out`/`t_state` registers.

## Test plan
- Reset, `run`=1, IR=0 (LDA):
  - After reset release, `out` steps through T1 (pc_out, mar_ld), then T2 (pc_inc), then T3 (ram_out, ir_ld), then T4 (ir_out, mar_ld), then T5 (ram_out, a_ld).
  - The next cycle is T1.
- IR=2 (SUB): T6 word equals alu_out, a_ld, flag_ld, alu_sub. Instruction length is 6 cycles.
- IR=5 (JZ):
  - With zf=1: T4 word equals ir_out, pc_ld.
  - With zf=0: T4 word is 0.
  - With the macro undefined: `ill_op` pulses after T3 and the instruction is 3 cycles long.
- IR=9: `ill_op`=1 for exactly one cycle after T3, and T1 follows immediately.
- `run`=0 at the end of an OUT instruction:
  - The sequencer sits in IDLE with `out`=0 for 5 cycles.
  - It enters T1 on the first falling edge after `run` rises.
- IR=F (HLT):
  - `halted`=1 and `out` equals hlt only, holding for 20 cycles.
  - `clr` pulsed low in HALT or mid-ADD (T5) immediately gives `out`=0 and IDLE.
